dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the simple CPU: the slave end of the load/store interface driven by the control unit's MemRead/MemWrite strobes. It accepts one request at a time, inserts a programmable number of wait states, and performs RV32I byte, halfword or word stores with byte lanes. Loads return sign- or zero-extended data through a valid/ready response handshake. It sits between the datapath's ALU address/rs2 outputs and the writeback mux.

## Interface
- ADDR_W, 10: word-address bits; memory depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states between acceptance and access (0 to 15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- MemRead  in  1  load request qualifier.
- MemWrite  in  1  store request qualifier.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  out  32  load result, extended to 32 bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- err  out  1  access fault, valid while resp_valid is high.

## Operation
- FSM states are IDLE, WAIT, ACCESS and RESP. The reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, rdata=0, err=0. Memory contents are not reset.
- **IDLE**
  - req_ready=1.
  - A request is accepted on an edge where req_valid=1 and MemRead is the inverse of MemWrite. On acceptance, addr, wdata, funct3 and the operation are captured.
  - Next state is WAIT with counter=WAIT_CYCLES. If WAIT_CYCLES=0, next state is ACCESS.
  - If MemRead and MemWrite are both 1, or both 0, the request is not accepted and there is no state change.
- **WAIT**
  - Counter decrements each cycle.
  - The FSM leaves for ACCESS on the edge where counter==1.
- **ACCESS**
  - Lasts one cycle. The array index is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
  - Stores write on the exiting edge, with little-endian byte enables:
    - SB: lane addr[1:0].
    - SH: lanes {addr[1],0} and {addr[1],1}.
    - SW: all lanes.
  - Loads register the word, then select the lane the same way. B and H are sign-extended; BU and HU are zero-extended; W is unchanged.
  - Stores return rdata=0.
- **RESP**
  - resp_valid=1. rdata and err are held stable until an edge with resp_ready=1, then the FSM returns to IDLE.
  - req_ready=0 in every state except IDLE.
- Illegal funct3 values (011, 110, 111, and 1xx on a store) are treated as W.

## Timing
- Acceptance edge = edge 0. ACCESS is entered after edge WAIT_CYCLES. resp_valid rises after edge WAIT_CYCLES+1.
- Default load-to-response latency is 3 edges.
- Minimum throughput is one request per WAIT_CYCLES+3 cycles; a new request can be accepted on the cycle after the response handshake.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and the outputs return to their reset values.
  - A store captured but not yet written is dropped.
  - If rst is high at the ACCESS exit edge, memory is not written.
- resp_ready high before resp_valid has no effect.

## Configuration
- DMEM_MISALIGN_TRAP_EN
  - **Defined:** the following are faults:
    - halfword access with addr[0]=1;
    - word access with addr[1:0]≠0;
    - illegal funct3.
  - On a fault, the store writes nothing, rdata=0 and err=1 in RESP. Timing is unchanged.
  - **Undefined:** err is tied 0. Misaligned accesses use the lane rules above, with the ignored low address bits forced to zero.

## Test plan
- SW 0xDEADBEEF to 0x40, then LW 0x40 -> rdata=0xDEADBEEF, err=0, resp_valid 3 edges after acceptance.
- SB 0x80 to 0x41, then:
  - LB 0x41 -> 0xFFFFFF80;
  - LBU 0x41 -> 0x00000080;
  - LW 0x40 -> 0xDEAD80EF.
- SH 0x1234 to 0x42, then:
  - LW 0x40 -> 0x123480EF;
  - LH 0x42 -> 0x00001234.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid=1 and rdata stable, req_ready=0. The handshake then returns the FSM to IDLE. A request with MemRead=MemWrite=1 is never accepted.
- Pulse rst during the WAIT of an SW 0x0 to 0x80 -> outputs reset; a following LW 0x80 returns the previous contents.
- With DMEM_MISALIGN_TRAP_EN:
  - LW 0x42 -> err=1, rdata=0;
  - SH 0x43 -> err=1 and memory unchanged;
  - without the macro, err stays 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with wait states and RV32I byte lanes.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned or illegal-size accesses into err responses.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               we_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         f3_q;
    logic [31:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]  idx;
    logic               accept, legal, is_b, is_h, fault;
    logic [3:0]         be;
    logic [31:0]        word, wsh, ld;
    logic [7:0]         bsel;
    logic [15:0]        hsel;
    logic               unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign accept      = req_valid && (MemRead ^ MemWrite) && state_q == IDLE;
    assign req_ready   = state_q == IDLE;
    assign resp_valid  = state_q == RESP;
    assign rdata       = rdata_q;
    assign err         = err_q;
    always_comb begin
        idx   = addr_q[ADDR_W+1:2];
        legal = f3_q inside {3'b000, 3'b001, 3'b010} || (!we_q && f3_q inside {3'b100, 3'b101});
        is_b  = legal && f3_q[1:0] == 2'b00;
        is_h  = legal && f3_q[1:0] == 2'b01;
`ifdef DMEM_MISALIGN_TRAP_EN
        fault = !legal || (is_h && addr_q[0]) || (!is_b && !is_h && addr_q[1:0] != 2'b00);
`else
        fault = 1'b0;
`endif
        // Halfword/word lanes ignore the low address bits below their size
        be    = is_b ? 4'b0001 << addr_q[1:0] : is_h ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wsh   = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
        word  = mem[idx];
        bsel  = word[{addr_q[1:0], 3'b000} +: 8];
        hsel  = word[{addr_q[1], 4'b0000} +: 16];
        ld    = is_b ? {{24{~f3_q[2] & bsel[7]}}, bsel} : is_h ? {{16{~f3_q[2] & hsel[15]}}, hsel} : word;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = WAIT_CYCLES == 0 ? ACCESS : WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? ACCESS : WAIT;
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = (we_q || fault) ? 32'd0 : ld;
                err_d   = fault;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= MemWrite;
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
                f3_q    <= funct3;
            end
        end
    end
    // rst gate covers reset asserted coincident with the ACCESS exit edge
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && we_q && !fault && !rst)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench against a byte-array reference model.
module tb_dmem_responder;
    localparam int WC = 2;
    typedef struct {logic [31:0] r; logic e; int acc;} exp_t;
    logic        clk = 0, rst = 1, req_valid = 0, MemRead = 0, MemWrite = 0, resp_ready = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [2:0]  funct3 = 0;
    logic        req_ready, resp_valid, err;
    logic [31:0] rdata;
    logic [7:0]  mm [0:4095];
    exp_t        q[$];
    int          nvec = 0, nerr = 0, cyc = 0;
    bit          hold = 0, seen = 0;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f3, output logic [31:0] r, output logic e);
        bit          legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        int          sz = !legal ? 4 : f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        int          ea;
        logic [31:0] v = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        e = !legal || (a % sz != 0);
`else
        e = 0;
`endif
        ea = int'(a % 4096) & ~(sz - 1);
        if (we) begin
            if (!e) for (int i = 0; i < sz; i++) mm[ea + i] = d[8*i +: 8];
            r = 0;
        end else begin
            for (int i = 0; i < sz; i++) v |= 32'(mm[ea + i]) << (8 * i);
            if (sz < 4 && !f3[2] && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
            r = e ? 32'd0 : v;
        end
    endfunction

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input bit push = 1);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("req_ready");
            return;
        end
        req_valid = 1; MemWrite = we; MemRead = !we; addr = a; wdata = d; funct3 = f3;
        @(posedge clk);
        #1;
        req_valid = 0;
        if (push) begin
            model(we, a, d, f3, x.r, x.e);
            x.acc = cyc;
            q.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) timeout("drain");
    endtask

    // Monitor: pick resp_ready for the coming edge, then check a response that will hand off on it
    initial forever begin
        @(negedge clk);
        resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (resp_valid && !seen) begin
            seen = 1;
            if (q.size() != 0) chk("latency", 32'(cyc - q[0].acc), 32'(WC + 1));
        end
        if (resp_valid && resp_ready) begin
            seen = 0;
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_resp: got rdata %h with no request pending", rdata);
            end else begin
                chk("rdata", rdata, q[0].r);
                chk("err", {31'd0, err}, {31'd0, q[0].e});
                void'(q.pop_front());
            end
        end
    end

    initial begin
        exp_t x;
        int   n;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 64; i++) issue(1, 32'(i * 4), $urandom, 3'b010);
        issue(1, 32'h40, 32'hDEADBEEF, 3'b010);
        issue(0, 32'h40, 0, 3'b010);
        issue(1, 32'h41, 32'h80, 3'b000);
        issue(0, 32'h41, 0, 3'b000);
        issue(0, 32'h41, 0, 3'b100);
        issue(0, 32'h40, 0, 3'b010);
        issue(1, 32'h42, 32'h1234, 3'b001);
        issue(0, 32'h40, 0, 3'b010);
        issue(0, 32'h42, 0, 3'b001);
        issue(0, 32'h42, 0, 3'b010);
        issue(1, 32'h43, 32'hAAAA, 3'b001);
        issue(0, 32'h40, 0, 3'b010);
        drain();
        hold = 1;
        issue(0, 32'h40, 0, 3'b010);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) timeout("bp_wait");
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            if (q.size() != 0) chk("bp_rdata", rdata, q[0].r);
        end
        hold = 0;
        drain();
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            req_valid = 1; MemRead = b[0]; MemWrite = b[0]; addr = 32'h40; funct3 = 3'b010;
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("bad_qual_ready", {31'd0, req_ready}, 32'd1);
            end
        end
        req_valid = 0;
        issue(1, 32'h80, 32'h0, 3'b010, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 0;
        issue(0, 32'h80, 0, 3'b010);
        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 1), {$urandom_range(0, 1) ? 20'($urandom) : 20'd0, 4'd0, 8'($urandom)},
                  $urandom, 3'($urandom));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
